alu_ctrl_seq: RTL and testbench

Sequential ALU control unit feeding the datapath ALU: accepts decoded instruction fields (opcode, funct) over a valid/ready handshake, translates them into the ALU's 4-bit `ALU_control` and 3-bit `bonus_control` codes, and presents them from a registered output stage with its own valid/ready handshake. It also enforces multiplier occupancy: after a multiply is consumed, it stalls for a configurable number of cycles before issuing the next control word. It sits between the instruction decoder and the ALU in the CPU datapath.

---
 rtl/alu_ctrl_seq_if.sv | 29 ++
 rtl/alu_ctrl_seq.sv | 151 +++++++++++++++
 tb/tb_alu_ctrl_seq.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_seq_if.sv
// Handshake bundle between the instruction decoder, alu_ctrl_seq and the ALU stage.
//   instr_valid_i / instr_ready_o : decoded-instruction handshake (opcode_i, funct_i)
//   ctrl_valid_o  / ctrl_ready_i  : control-word handshake (alu_ctrl_o, bonus_ctrl_o, illegal_o)
//   busy_o                        : multiplier occupancy stall in progress
// Member names carry the direction suffix as seen from the control unit.
// modport slave  : the control unit itself
// modport master : the surrounding decoder/ALU (or a testbench)
interface alu_ctrl_seq_if;
  logic       instr_valid_i;
  logic       instr_ready_o;
  logic [5:0] opcode_i;
  logic [5:0] funct_i;
  logic       ctrl_valid_o;
  logic       ctrl_ready_i;
  logic [3:0] alu_ctrl_o;
  logic [2:0] bonus_ctrl_o;
  logic       illegal_o;
  logic       busy_o;

  modport slave (
    input  instr_valid_i, opcode_i, funct_i, ctrl_ready_i,
    output instr_ready_o, ctrl_valid_o, alu_ctrl_o, bonus_ctrl_o, illegal_o, busy_o
  );

  modport master (
    output instr_valid_i, opcode_i, funct_i, ctrl_ready_i,
    input  instr_ready_o, ctrl_valid_o, alu_ctrl_o, bonus_ctrl_o, illegal_o, busy_o
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// Sequential ALU control unit. Translates opcode/funct into the ALU's 4-bit control code and
// 3-bit bonus (compare) code, presents them from a registered output stage and stalls after a
// consumed multiply for MUL_LAT-1 cycles.
// Ports:
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-high reset
//   bus_io  : alu_ctrl_seq_if.slave (instruction in, control word out, busy)
// Parameters:
//   MUL_LAT : multiplier occupancy in cycles, 1..15
// Build option:
//   ALU_CTRL_BONUS_EN : decode R-type funct 0x2C..0x2F as CMP with sgt/sle/sge/ge(src2-1)
module alu_ctrl_seq #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  alu_ctrl_seq_if.slave bus_io
);

  localparam logic [3:0] AluAnd = 4'd0;
  localparam logic [3:0] AluOr  = 4'd1;
  localparam logic [3:0] AluAdd = 4'd2;
  localparam logic [3:0] AluSub = 4'd6;
  localparam logic [3:0] AluCmp = 4'd7;
  localparam logic [3:0] AluMul = 4'd8;
  localparam logic [3:0] AluNor = 4'd12;

  localparam bit         MulStalls = (MUL_LAT > 1);
  localparam logic [3:0] MulCnt    = 4'(MUL_LAT - 1);

  typedef enum logic [1:0] {StIdle, StHold, StMulWait} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] alu_q, alu_d;
  logic [2:0] bonus_q, bonus_d;
  logic       illegal_q, illegal_d;

  logic [3:0] dec_alu;
  logic [2:0] dec_bonus;
  logic       dec_illegal;
  logic       consume, held_mul, instr_ready, accept;

  // Instruction decode
  always_comb begin
    dec_alu     = AluAnd;
    dec_bonus   = 3'b000;
    dec_illegal = 1'b0;
    if (bus_io.opcode_i == 6'h00) begin
      case (bus_io.funct_i)
        6'h20: dec_alu = AluAdd;
        6'h22: dec_alu = AluSub;
        6'h24: dec_alu = AluAnd;
        6'h25: dec_alu = AluOr;
        6'h27: dec_alu = AluNor;
        6'h2A: dec_alu = AluCmp;
        6'h18: dec_alu = AluMul;
`ifdef ALU_CTRL_BONUS_EN
        6'h2C: begin dec_alu = AluCmp; dec_bonus = 3'b001; end
        6'h2D: begin dec_alu = AluCmp; dec_bonus = 3'b010; end
        6'h2E: begin dec_alu = AluCmp; dec_bonus = 3'b011; end
        6'h2F: begin dec_alu = AluCmp; dec_bonus = 3'b101; end
`else
        // 0x2C..0x2F fall through to illegal in the base build
`endif
        default: dec_illegal = 1'b1;
      endcase
    end else begin
      case (bus_io.opcode_i)
        6'h08, 6'h23, 6'h2B: dec_alu = AluAdd;
        6'h0C: dec_alu = AluAnd;
        6'h0D: dec_alu = AluOr;
        6'h0A: dec_alu = AluCmp;
        6'h04: begin dec_alu = AluCmp; dec_bonus = 3'b110; end
        6'h05: begin dec_alu = AluCmp; dec_bonus = 3'b100; end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  // Handshake. A consumed MUL never allows a same-cycle reload; the stall must run first.
  always_comb begin
    consume     = (state_q == StHold) && bus_io.ctrl_ready_i;
    held_mul    = (alu_q == AluMul);
    instr_ready = !rst_i &&
                  ((state_q == StIdle) || (consume && !(held_mul && MulStalls)));
    accept      = bus_io.instr_valid_i && instr_ready;
  end

  // Next state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_d     = alu_q;
    bonus_d   = bonus_q;
    illegal_d = illegal_q;
    if (accept) begin
      alu_d     = dec_alu;
      bonus_d   = dec_bonus;
      illegal_d = dec_illegal;
    end
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StHold;
      end
      StHold: begin
        if (consume) begin
          if (held_mul && MulStalls) begin
            state_d = StMulWait;
            cnt_d   = MulCnt;
          end else if (!accept) begin
            state_d = StIdle;
          end
        end
      end
      StMulWait: begin
        if (cnt_q <= 4'd1) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      alu_q     <= 4'd0;
      bonus_q   <= 3'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_q     <= alu_d;
      bonus_q   <= bonus_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus_io.instr_ready_o = instr_ready;
  assign bus_io.ctrl_valid_o  = (state_q == StHold);
  assign bus_io.busy_o        = (state_q == StMulWait);
  assign bus_io.alu_ctrl_o    = alu_q;
  assign bus_io.bonus_ctrl_o  = bonus_q;
  assign bus_io.illegal_o     = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq with MUL_LAT = 4. Compares a packed snapshot of all outputs
// {ctrl_valid, alu_ctrl, bonus_ctrl, illegal, busy, instr_ready} against hand-computed words.
module tb_alu_ctrl_seq;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_ctrl_seq_if bus ();

  alu_ctrl_seq #(.MUL_LAT(4)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus.slave)
  );

  always #5 clk = ~clk;

  localparam int NTab = 11;
  localparam logic [5:0] TOp    [NTab] = '{6'h08, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0A,
                                           6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  localparam logic [5:0] TFunct [NTab] = '{6'h3F, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                           6'h2A, 6'h24, 6'h01, 6'h25, 6'h27};
  localparam logic [3:0] TAlu   [NTab] = '{4'd2, 4'd2, 4'd2, 4'd0, 4'd1, 4'd7,
                                           4'd7, 4'd0, 4'd0, 4'd1, 4'd12};
  localparam logic       TIll   [NTab] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                           1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  function automatic logic [10:0] snap();
    return {bus.ctrl_valid_o, bus.alu_ctrl_o, bus.bonus_ctrl_o, bus.illegal_o, bus.busy_o,
            bus.instr_ready_o};
  endfunction

  // Full expected word
  function automatic logic [10:0] ew(input logic v, input logic [3:0] alu, input logic [2:0] bon,
                                     input logic ill, input logic busy, input logic rdy);
    return {v, alu, bon, ill, busy, rdy};
  endfunction

  // Control-only view {valid, busy, ready}; payload is left unchecked while empty
  function automatic logic [10:0] ctl_obs();
    return {8'd0, bus.ctrl_valid_o, bus.busy_o, bus.instr_ready_o};
  endfunction

  function automatic logic [10:0] ctl_exp(input logic v, input logic busy, input logic rdy);
    return {8'd0, v, busy, rdy};
  endfunction

  task automatic check_eq(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %03h expected %03h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [5:0] op, input logic [5:0] fn);
    bus.instr_valid_i = 1'b1;
    bus.opcode_i      = op;
    bus.funct_i       = fn;
  endtask

  initial begin
    rst = 1'b1;
    bus.instr_valid_i = 1'b0;
    bus.opcode_i      = 6'h00;
    bus.funct_i       = 6'h00;
    bus.ctrl_ready_i  = 1'b0;
    #2;
    check_eq("reset", snap(), ew(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0));

    // Reset release, add into HOLD, then reset mid-HOLD
    tick();
    rst = 1'b0;
    ld(6'h00, 6'h20);
    #1;
    check_eq("idle_ready", snap(), ew(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1));
    tick();
    check_eq("add_held", snap(), ew(1'b1, 4'd2, 3'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    #1;
    check_eq("rst_mid_hold", snap(), ew(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    #1;
    check_eq("post_rst_idle", snap(), ew(1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1));
    tick();
    check_eq("post_rst_accept", snap(), ew(1'b1, 4'd2, 3'd0, 1'b0, 1'b0, 1'b0));

    // Stream add -> sub -> or -> nor, one per cycle
    bus.ctrl_ready_i = 1'b1;
    ld(6'h00, 6'h22);
    #1;
    check_eq("hold_ready", snap(), ew(1'b1, 4'd2, 3'd0, 1'b0, 1'b0, 1'b1));
    tick();
    check_eq("stream_sub", snap(), ew(1'b1, 4'd6, 3'd0, 1'b0, 1'b0, 1'b1));
    ld(6'h00, 6'h25);
    tick();
    check_eq("stream_or", snap(), ew(1'b1, 4'd1, 3'd0, 1'b0, 1'b0, 1'b1));
    ld(6'h00, 6'h27);
    tick();
    check_eq("stream_nor", snap(), ew(1'b1, 4'd12, 3'd0, 1'b0, 1'b0, 1'b1));
    bus.instr_valid_i = 1'b0;
    tick();
    check_eq("stream_drain", ctl_obs(), ctl_exp(1'b0, 1'b0, 1'b1));

    // beq held under back-pressure for 3 cycles, then bne
    bus.ctrl_ready_i = 1'b0;
    ld(6'h04, 6'h00);
    tick();
    check_eq("beq", snap(), ew(1'b1, 4'd7, 3'b110, 1'b0, 1'b0, 1'b0));
    ld(6'h05, 6'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_hold", snap(), ew(1'b1, 4'd7, 3'b110, 1'b0, 1'b0, 1'b0));
    end
    bus.ctrl_ready_i = 1'b1;
    #1;
    check_eq("bp_release", snap(), ew(1'b1, 4'd7, 3'b110, 1'b0, 1'b0, 1'b1));
    tick();
    check_eq("bne", snap(), ew(1'b1, 4'd7, 3'b100, 1'b0, 1'b0, 1'b1));
    bus.instr_valid_i = 1'b0;
    tick();
    check_eq("bne_drain", ctl_obs(), ctl_exp(1'b0, 1'b0, 1'b1));

    // mult, then add: 3 busy cycles, IDLE after N+3, add loaded on the following edge
    ld(6'h00, 6'h18);
    tick();
    ld(6'h00, 6'h20);
    #1;
    check_eq("mul_held", snap(), ew(1'b1, 4'd8, 3'd0, 1'b0, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("mul_busy", ctl_obs(), ctl_exp(1'b0, 1'b1, 1'b0));
    end
    tick();
    check_eq("mul_idle", ctl_obs(), ctl_exp(1'b0, 1'b0, 1'b1));
    tick();
    check_eq("add_after_mul", snap(), ew(1'b1, 4'd2, 3'd0, 1'b0, 1'b0, 1'b1));

    // Illegal opcode, then a legal add clears illegal_o
    ld(6'h3F, 6'h00);
    tick();
    check_eq("illegal_op", snap(), ew(1'b1, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1));
    ld(6'h00, 6'h20);
    tick();
    check_eq("illegal_clear", snap(), ew(1'b1, 4'd2, 3'd0, 1'b0, 1'b0, 1'b1));

    // Bonus funct 0x2D
    ld(6'h00, 6'h2D);
    tick();
`ifdef ALU_CTRL_BONUS_EN
    check_eq("funct_2d", snap(), ew(1'b1, 4'd7, 3'b010, 1'b0, 1'b0, 1'b1));
`else
    check_eq("funct_2d", snap(), ew(1'b1, 4'd0, 3'd0, 1'b1, 1'b0, 1'b1));
`endif

    // Remaining decode entries, streamed
    for (int i = 0; i < NTab; i++) begin
      ld(TOp[i], TFunct[i]);
      tick();
      check_eq($sformatf("tab%0d", i), snap(), ew(1'b1, TAlu[i], 3'd0, TIll[i], 1'b0, 1'b1));
    end
    bus.instr_valid_i = 1'b0;
    tick();
    check_eq("final_idle", ctl_obs(), ctl_exp(1'b0, 1'b0, 1'b1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
